// File: rtl/cursor_ctrl_pkg.sv
// cursor_ctrl_pkg: toggle FSM encoding and index-width helper shared by the cursor controller.
package cursor_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_READ, PULSE, RELEASE} tog_state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchroniser, counter debouncer and one-cycle press pulse for a raw button.
module button_debounce
  import cursor_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);
  localparam int CW = idx_w(DEBOUNCE_CYCLES);
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, press_q, press_d, flip;
  always_comb begin
    flip = (sync_q[1] != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    cnt_d = (sync_q[1] != level_q && !flip) ? cnt_q + 1'b1 : '0;
    level_d = flip ? ~level_q : level_q;
    press_d = flip & ~level_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      cnt_q <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end
  assign level = level_q;
  assign press = press_q;
endmodule

// File: rtl/cursor_ctrl.sv
// cursor_ctrl: debounced grid cursor with registered cell address and a toggle-request FSM.
module cursor_ctrl
  import cursor_ctrl_pkg::*;
#(
  parameter int P_PARAM_M = 5,
  parameter int P_PARAM_N = 5,
  parameter int WIDTH = 12,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_toggle,
  input  logic enable,
  output logic [idx_w(P_PARAM_M)-1:0] cursor_row,
  output logic [idx_w(P_PARAM_N)-1:0] cursor_col,
  output logic [WIDTH-1:0] read_address,
  output logic modify,
  output logic busy
);
  localparam int RW = idx_w(P_PARAM_M);
  localparam int CLW = idx_w(P_PARAM_N);
  logic [4:0] raw, level, press;
  logic [RW-1:0] row_q, row_d;
  logic [CLW-1:0] col_q, col_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  tog_state_e state_q, state_d;
  logic pcnt_q, pcnt_d, modify_q, modify_d;
  logic mv, v_up, v_dn, h_lf, h_rt;
  assign raw = {btn_toggle, btn_right, btn_left, btn_down, btn_up};
  for (genvar i = 0; i < 5; i++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .rst_n(rst_n), .btn(raw[i]), .level(level[i]), .press(press[i])
    );
  end
  // a toggle press in the same IDLE cycle swallows any move
  always_comb begin
    mv = enable && state_q == IDLE && !press[4];
    v_up = mv & press[0] & ~press[1];
    v_dn = mv & press[1] & ~press[0];
    h_lf = mv & press[2] & ~press[3];
    h_rt = mv & press[3] & ~press[2];
    row_d = v_up ? (row_q == '0 ? RW'(P_PARAM_M - 1) : row_q - 1'b1)
          : v_dn ? (row_q == RW'(P_PARAM_M - 1) ? '0 : row_q + 1'b1) : row_q;
    col_d = h_lf ? (col_q == '0 ? CLW'(P_PARAM_N - 1) : col_q - 1'b1)
          : h_rt ? (col_q == CLW'(P_PARAM_N - 1) ? '0 : col_q + 1'b1) : col_q;
    addr_d = WIDTH'(int'(row_d) * P_PARAM_N + int'(col_d));
  end
  always_comb begin
    state_d = state_q;
    pcnt_d = 1'b0;
    if (!enable) state_d = IDLE;
    else begin
      unique case (state_q)
        IDLE: state_d = press[4] ? WAIT_READ : IDLE;
        WAIT_READ: state_d = PULSE;
        PULSE: begin
          state_d = pcnt_q ? RELEASE : PULSE;
          pcnt_d = ~pcnt_q;
        end
        RELEASE: state_d = level[4] ? RELEASE : IDLE;
        default: state_d = IDLE;
      endcase
    end
    modify_d = state_d == PULSE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
      addr_q <= '0;
      state_q <= IDLE;
      pcnt_q <= 1'b0;
      modify_q <= 1'b0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      addr_q <= addr_d;
      state_q <= state_d;
      pcnt_q <= pcnt_d;
      modify_q <= modify_d;
    end
  end
  assign cursor_row = row_q;
  assign cursor_col = col_q;
  assign read_address = addr_q;
  assign modify = modify_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_cursor_ctrl.sv
// tb_cursor_ctrl: directed self-checking bench for cursor_ctrl on a 5x5 grid with 4-cycle debounce.
module tb_cursor_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1;
  logic [4:0] btns = '0;
  logic [2:0] cursor_row, cursor_col;
  logic [11:0] read_address;
  logic modify, busy;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  cursor_ctrl #(.P_PARAM_M(5), .P_PARAM_N(5), .WIDTH(12), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btns[0]), .btn_down(btns[1]), .btn_left(btns[2]), .btn_right(btns[3]),
    .btn_toggle(btns[4]), .enable(enable),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .read_address(read_address),
    .modify(modify), .busy(busy)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tap(input logic [4:0] mask);
    btns = mask;
    tick(8);
    btns = '0;
    tick(10);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(2);
    checks++; if (cursor_row !== 3'd0) begin errors++; $display("FAIL reset_row got %0d want 0", cursor_row); end
    checks++; if (cursor_col !== 3'd0) begin errors++; $display("FAIL reset_col got %0d want 0", cursor_col); end
    checks++; if (read_address !== 12'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", read_address); end
    checks++; if (modify !== 1'b0) begin errors++; $display("FAIL reset_modify got %0b want 0", modify); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_wrap;
    tap(5'b00001);
    checks++; if (cursor_row !== 3'd4) begin errors++; $display("FAIL up_wrap_row got %0d want 4", cursor_row); end
    checks++; if (read_address !== 12'd20) begin errors++; $display("FAIL up_wrap_addr got %0d want 20", read_address); end
    repeat (4) tap(5'b01000);
    checks++; if (cursor_col !== 3'd4) begin errors++; $display("FAIL right4_col got %0d want 4", cursor_col); end
    checks++; if (read_address !== 12'd24) begin errors++; $display("FAIL right4_addr got %0d want 24", read_address); end
    tap(5'b01000);
    checks++; if (cursor_col !== 3'd0) begin errors++; $display("FAIL right_wrap_col got %0d want 0", cursor_col); end
    checks++; if (read_address !== 12'd20) begin errors++; $display("FAIL right_wrap_addr got %0d want 20", read_address); end
  endtask

  task automatic test_debounce;
    btns = 5'b00100;
    tick(3);
    btns = '0;
    tick(10);
    checks++; if (cursor_col !== 3'd0) begin errors++; $display("FAIL glitch_col got %0d want 0", cursor_col); end
    btns = 5'b00100;
    tick(20);
    checks++; if (cursor_col !== 3'd4) begin errors++; $display("FAIL hold_early_col got %0d want 4", cursor_col); end
    tick(180);
    btns = '0;
    tick(10);
    checks++; if (cursor_col !== 3'd4) begin errors++; $display("FAIL hold_end_col got %0d want 4", cursor_col); end
    checks++; if (read_address !== 12'd24) begin errors++; $display("FAIL hold_end_addr got %0d want 24", read_address); end
    tap(5'b00001);
    tap(5'b00001);
    tap(5'b00100);
    checks++; if (read_address !== 12'd13) begin errors++; $display("FAIL pos_2_3_addr got %0d want 13", read_address); end
  endtask

  task automatic test_toggle;
    int hi = 0, first = -1, bad_addr = 0, hi2 = 0;
    btns = 5'b10000;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (modify) begin hi++; if (first < 0) first = k; end
      if (read_address !== 12'd13) bad_addr++;
      if (k == 12) btns[1] = 1'b1;
      if (k == 20) begin
        btns[1] = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL release_busy got %0b want 1", busy); end
      end
    end
    btns = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (modify) hi2++;
    end
    checks++; if (hi !== 2) begin errors++; $display("FAIL toggle_pulse_len got %0d want 2", hi); end
    checks++; if (first !== 8) begin errors++; $display("FAIL toggle_pulse_start got %0d want 8", first); end
    checks++; if (bad_addr !== 0) begin errors++; $display("FAIL toggle_addr_frozen got %0d want 0", bad_addr); end
    checks++; if (cursor_row !== 3'd2) begin errors++; $display("FAIL busy_move_row got %0d want 2", cursor_row); end
    checks++; if (hi2 !== 0) begin errors++; $display("FAIL toggle_second_pulse got %0d want 0", hi2); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL toggle_idle_busy got %0b want 0", busy); end
  endtask

  task automatic test_enable;
    int hi = 0;
    enable = 1'b0;
    btns = 5'b10010;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (modify) hi++;
    end
    btns = '0;
    tick(10);
    checks++; if (hi !== 0) begin errors++; $display("FAIL disabled_modify got %0d want 0", hi); end
    checks++; if (cursor_row !== 3'd2) begin errors++; $display("FAIL disabled_row got %0d want 2", cursor_row); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL disabled_busy got %0b want 0", busy); end
    enable = 1'b1;
    btns = 5'b10000;
    tick(8);
    checks++; if (modify !== 1'b1) begin errors++; $display("FAIL pulse_before_drop got %0b want 1", modify); end
    enable = 1'b0;
    tick(1);
    checks++; if (modify !== 1'b0) begin errors++; $display("FAIL drop_modify got %0b want 0", modify); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %0b want 0", busy); end
    btns = '0;
    tick(10);
    enable = 1'b1;
    tick(2);
  endtask

  task automatic test_same_cycle;
    int hi = 0;
    tap(5'b00011);
    checks++; if (cursor_row !== 3'd2) begin errors++; $display("FAIL up_down_row got %0d want 2", cursor_row); end
    btns = 5'b11000;
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      if (modify) hi++;
      if (k == 8) btns = '0;
    end
    checks++; if (cursor_col !== 3'd3) begin errors++; $display("FAIL toggle_right_col got %0d want 3", cursor_col); end
    checks++; if (hi !== 2) begin errors++; $display("FAIL toggle_right_pulse got %0d want 2", hi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL toggle_right_busy got %0b want 0", busy); end
  endtask

  task automatic test_reset_mid_pulse;
    int hi = 0;
    btns = 5'b10000;
    tick(8);
    checks++; if (modify !== 1'b1) begin errors++; $display("FAIL pre_reset_modify got %0b want 1", modify); end
    rst_n = 1'b0;
    #1;
    checks++; if (modify !== 1'b0) begin errors++; $display("FAIL async_reset_modify got %0b want 0", modify); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got %0b want 0", busy); end
    checks++; if (cursor_row !== 3'd0) begin errors++; $display("FAIL async_reset_row got %0d want 0", cursor_row); end
    checks++; if (cursor_col !== 3'd0) begin errors++; $display("FAIL async_reset_col got %0d want 0", cursor_col); end
    checks++; if (read_address !== 12'd0) begin errors++; $display("FAIL async_reset_addr got %0d want 0", read_address); end
    btns = '0;
    tick(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (modify) hi++;
    end
    checks++; if (hi !== 0) begin errors++; $display("FAIL post_reset_pulse got %0d want 0", hi); end
  endtask

  initial begin
    test_reset;
    test_wrap;
    test_debounce;
    test_toggle;
    test_enable;
    test_same_cycle;
    test_reset_mid_pulse;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cursor_ctrl.md
CURSOR_CTRL -- requirements
Module: cursor_ctrl

Interface
REQ-001 SHALL have parameter P_PARAM_M, default 5, grid rows.
REQ-002 SHALL have parameter P_PARAM_N, default 5, grid columns.
REQ-003 SHALL have parameter WIDTH, default 12, cell-address width.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 16, stable cycles required to accept a button level.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have ports btn_up, btn_down, btn_left, btn_right  input  1 each  raw asynchronous move buttons, active-high.
REQ-008 SHALL have port btn_toggle  input  1  raw asynchronous toggle-cell button, active-high.
REQ-009 SHALL have port enable  input  1  editing allowed (simulation paused).
REQ-010 SHALL have port cursor_row  output  clog2(P_PARAM_M)  current row.
REQ-011 SHALL have port cursor_col  output  clog2(P_PARAM_N)  current column.
REQ-012 SHALL have port read_address  output  WIDTH  cell address fed to the memory read port and the single-cell modifier.
REQ-013 SHALL have port modify  output  1  toggle request to the single-cell modifier; its rising edge triggers one cell inversion.
REQ-014 SHALL have port busy  output  1  high whenever the toggle FSM is not IDLE.

Function
REQ-015 Each button SHALL pass a 2-flop synchroniser, then a debouncer; the debounced level changes only after DEBOUNCE_CYCLES consecutive cycles of the opposite synchronised value.
REQ-016 A press pulse SHALL be one cycle, on the debounced 0->1 transition; holding a button produces no further pulses.
REQ-017 Up pulse SHALL set row to row-1, wrapping 0 -> P_PARAM_M-1; down SHALL set row+1, wrapping P_PARAM_M-1 -> 0.
REQ-018 Left/right SHALL do the same on cursor_col modulo P_PARAM_N.
REQ-019 Up and down pulses in the same cycle SHALL leave row unchanged; left and right together SHALL leave column unchanged; one vertical and one horizontal pulse together SHALL both apply.
REQ-020 read_address SHALL be registered and equal row*P_PARAM_N+col, updated on the same edge as row/col, truncated to WIDTH.
REQ-021 Toggle FSM states: IDLE, WAIT_READ, PULSE, RELEASE.
REQ-022 IDLE -> WAIT_READ on toggle pulse with enable=1; WAIT_READ lasts exactly 1 cycle, covering the memory's 1-cycle read latency.
REQ-023 PULSE SHALL hold modify=1 for exactly 2 cycles, then go to RELEASE.
REQ-024 RELEASE SHALL hold modify=0 and return to IDLE once debounced btn_toggle is 0.
REQ-025 Move pulses SHALL be ignored while busy=1, so read_address is frozen from WAIT_READ entry through RELEASE.
REQ-026 A toggle pulse and a move pulse in the same IDLE cycle: toggle SHALL win; the move is dropped.
REQ-027 enable=0 SHALL suppress all moves and toggle starts; enable falling in any non-IDLE state SHALL force IDLE with modify=0 next cycle.
REQ-028 modify SHALL be a registered output, 0 outside PULSE.

Reset
REQ-029 rst_n low SHALL asynchronously clear row, col, read_address and modify to 0, set FSM to IDLE and busy to 0.
REQ-030 rst_n low SHALL clear synchronisers, debounced levels and debounce counters to 0.
REQ-031 Reset mid-PULSE SHALL drop modify immediately; no pulse is emitted after release unless a new press is debounced.
REQ-032 Deassertion is handled by the system-level synchroniser; no local deassertion logic.

Structure
REQ-033 FSM state encoding and the clog2-based row/column widths SHALL live in the shared project package.
REQ-034 Synchroniser + debouncer + edge detect SHALL be one sub-module, button_debounce, instantiated five times.
REQ-035 Row*N+col SHALL use a constant multiply; no runtime divider.

Verification
REQ-036 M=N=5, DEBOUNCE_CYCLES=4: rst_n low then high -> row=0, col=0, read_address=0, modify=0, busy=0.
REQ-037 Press btn_up once from row 0 -> row=4, read_address=20; then btn_right from col 4 -> col=0.
REQ-038 3-cycle glitch on btn_left -> no change; press held 200 cycles -> exactly one column decrement.
REQ-039 Cursor at (2,3), enable=1, press toggle -> read_address=13 throughout; modify high exactly 2 cycles starting 2 cycles after the debounced edge; no second pulse until release and re-press.
REQ-040 enable=0, press toggle and btn_down -> modify stays 0, row unchanged; drop enable during PULSE -> modify=0 next cycle, FSM IDLE.
REQ-041 btn_up and btn_down debounced same cycle -> row unchanged; toggle and btn_right same cycle -> column unchanged, one modify pulse.
